fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, 32, PC/instruction-address width.
REQ-002 SHALL have parameter INST_W, 32, instruction width.
REQ-003 SHALL have parameter DEPTH, 4, queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-low reset).
REQ-006 SHALL have port rom_addr_o, output, ADDR_W: fetch address.
REQ-007 SHALL have port rom_ce_o, output, 1: fetch request this cycle.
REQ-008 SHALL have port rom_data_i, input, INST_W: instruction, combinational, same cycle as the request.
REQ-009 SHALL have port rom_valid_i, input, 1: rom_data_i valid; a request without valid is dropped and retried.
REQ-010 SHALL have port id_valid_o, output, 1: head entry valid.
REQ-011 SHALL have port id_ready_i, input, 1: ID accepts the head; pop = id_valid_o && id_ready_i.
REQ-012 SHALL have port id_pc_o, output, ADDR_W: head PC.
REQ-013 SHALL have port id_inst_o, output, INST_W: head instruction.
REQ-014 SHALL have port branch_flag_i, input, 1: popped instruction is a taken branch; honoured only in a pop cycle.
REQ-015 SHALL have port branch_target_addr_i, input, ADDR_W: branch target.
REQ-016 SHALL have port flush_i, input, 1: discard everything and redirect.
REQ-017 SHALL have port flush_pc_i, input, ADDR_W: flush redirect address.

Function
REQ-018 SHALL assert rom_ce_o when not flushing and (count < DEPTH or pop); rom_addr_o SHALL equal the pc register.
REQ-019 SHALL, in each cycle where rom_ce_o && rom_valid_i, push {pc, rom_data_i} at the tail and advance pc by 4, with ADDR_W wrap-around.
REQ-020 SHALL allow push and pop in the same cycle when full; the count is unchanged in that case.
REQ-021 SHALL present the head combinationally; id_valid_o SHALL be 0 when empty; a push into an empty queue SHALL become visible the next cycle (fetch-to-ID latency 1).
REQ-022 SHALL wrap pointers modulo DEPTH and SHALL never overflow or underflow.
REQ-023 SHALL implement FSM states RUN and SLOT_WAIT; the delay slot (next sequential instruction after a branch) SHALL always be preserved.
REQ-024 SHALL handle a RUN pop with branch_flag_i as follows:
- At least one entry remains after the pop: keep only the oldest remaining entry, discard the rest, suppress this cycle's push, and set pc to the target.
- Queue empty after the pop and this cycle's fetch is valid: push the fetched entry as the delay slot and set pc to the target.
- Otherwise: save the target to tgt_q and go to SLOT_WAIT.
REQ-025 SHALL, in SLOT_WAIT, fetch sequentially; on the first valid fetch it SHALL push it, set pc to tgt_q, and go to RUN. branch_flag_i SHALL be ignored in SLOT_WAIT.
REQ-026 SHALL give flush_i priority over everything:
- In the flush cycle: count to 0, no push, rom_ce_o=0, pc to flush_pc_i, state to RUN.
- id_valid_o SHALL be 0 the following cycle.
REQ-027 SHALL ignore branch_flag_i when there is no pop.

Reset
REQ-028 SHALL, while rst=0, force: pc=RESET_PC, count and pointers 0, state RUN, tgt_q 0, id_valid_o 0, rom_ce_o 0, id_pc_o 0, id_inst_o 0.
REQ-029 SHALL make the first request (rom_addr_o=RESET_PC) in the first clock after rst rises; reset asserted mid-operation SHALL discard all queued entries immediately.

Structure
REQ-030 SHALL take ADDR_W/INST_W defaults, RESET_PC, and the FSM state encoding from the shared defines header.
REQ-031 SHALL place entry storage in one sub-module, fetch_queue_mem: DEPTH x (ADDR_W+INST_W), one write port and a combinational read port; pointers and control stay in fetch_queue.

Verification
REQ-032 SHALL verify reset/steady state: release rst, rom_valid_i=1, id_ready_i=1 -> addresses 0x0,0x4,0x8 requested on consecutive cycles; id_pc_o=0x0 one cycle after the first request.
REQ-033 SHALL verify full: id_ready_i=0 with DEPTH=4 -> four pushes (0x0..0xC), then rom_ce_o=0; id_ready_i=1 -> push and pop occur in the same cycle.
REQ-034 SHALL verify a queued delay slot: queue {0x10 branch, 0x14, 0x18}, pop 0x10 with target 0x100 -> next heads 0x14 then 0x100; 0x18 is never presented.
REQ-035 SHALL verify SLOT_WAIT: branch popped with empty queue and rom_valid_i=0 for 3 cycles -> rom_addr_o holds the branch PC+4; on valid it is pushed and the next request is the target.
REQ-036 SHALL verify flush priority: flush_i=1 with flush_pc_i=0x180 in the same cycle as a branch pop -> queue empties, rom_ce_o=0 that cycle, next request 0x180, no delay slot kept.
REQ-037 SHALL verify wrap-around: pc=0xFFFF_FFFC fetched -> next request 0x0000_0000.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset PC and FSM encoding for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int          FQ_ADDR_W   = 32;
  localparam int          FQ_INST_W   = 32;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FQ_PC_STEP  = 32'd4;

  // RUN: normal sequential fetch. SLOT_WAIT: branch taken, delay slot not yet fetched.
  typedef enum logic [0:0] {
    RUN       = 1'b0,
    SLOT_WAIT = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side (ROM) and decode-side (ID) signals of the fetch queue.
interface fetch_queue_if import fetch_queue_pkg::*; #(
  parameter int ADDR_W = FQ_ADDR_W,
  parameter int INST_W = FQ_INST_W
);

  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ce_o;
  logic [INST_W-1:0] rom_data_i;
  logic              rom_valid_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_addr_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;

  modport master (
    output rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o,
    input  rom_data_i, rom_valid_i, id_ready_i, branch_flag_i,
           branch_target_addr_i, flush_i, flush_pc_i
  );

  modport slave (
    input  rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o,
    output rom_data_i, rom_valid_i, id_ready_i, branch_flag_i,
           branch_target_addr_i, flush_i, flush_pc_i
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, combinational read port.
module fetch_queue_mem #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from ROM, buffers {pc, inst}
// for ID, and handles taken branches with a preserved delay slot and flushes.
module fetch_queue import fetch_queue_pkg::*; #(
  parameter int                ADDR_W   = FQ_ADDR_W,
  parameter int                INST_W   = FQ_INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC)
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = PTR_W + 1;
  localparam int                ENT_W = ADDR_W + INST_W;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(FQ_PC_STEP);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  fq_state_e         state_q, state_d;

  logic              pop;
  logic              push;
  logic              rom_ce;
  logic              fetch_ok;
  logic              keep_one;
  logic [ENT_W-1:0]  head;

  always_comb begin
    pop      = (cnt_q != '0) && bus.id_ready_i;
    rom_ce   = rst && !bus.flush_i && ((cnt_q != FULL) || pop);
    fetch_ok = rom_ce && bus.rom_valid_i;
    push     = fetch_ok;
    keep_one = 1'b0;
    pc_d     = fetch_ok ? pc_q + STEP : pc_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    tgt_d    = tgt_q;

    if (bus.flush_i) begin
      push     = 1'b0;
      pc_d     = bus.flush_pc_i;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = RUN;
    end else if (state_q == SLOT_WAIT) begin
      // The delay slot is the first valid sequential fetch; then redirect.
      if (fetch_ok) begin
        pc_d    = tgt_q;
        state_d = RUN;
      end
    end else if (pop && bus.branch_flag_i) begin
      if (cnt_q > ONE) begin
        // Oldest remaining entry is the delay slot; everything after it is wrong-path.
        keep_one = 1'b1;
        push     = 1'b0;
        wr_ptr_d = rd_ptr_q + PTR_W'(2);
        cnt_d    = ONE;
        pc_d     = bus.branch_target_addr_i;
      end else if (fetch_ok) begin
        pc_d = bus.branch_target_addr_i;
      end else begin
        tgt_d   = bus.branch_target_addr_i;
        state_d = SLOT_WAIT;
      end
    end

    if (!bus.flush_i && !keep_one) begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + ONE;
        2'b01:   cnt_d = cnt_q - ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      state_q  <= RUN;
    end else begin
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      state_q  <= state_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({pc_q, bus.rom_data_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Storage is not reset, so the head is masked whenever the queue is empty.
  assign bus.rom_addr_o = pc_q;
  assign bus.rom_ce_o   = rom_ce;
  assign bus.id_valid_o = (cnt_q != '0);
  assign bus.id_pc_o    = bus.id_valid_o ? head[ENT_W-1:INST_W] : '0;
  assign bus.id_inst_o  = bus.id_valid_o ? head[INST_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue against a queue-level reference
// model; popped entries are checked by a separate scoreboard monitor.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  fetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.rom_data_i = rom_of(bus.rom_addr_o);

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  ent_t        sb[$];
  logic [31:0] mpc  = RESET_PC;
  logic [31:0] mtgt = '0;
  bit          slot = 1'b0;

  logic [31:0] last_addr, last_pc;
  logic        last_ce, last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit r_n, input bit v, input bit rdy, input bit br,
                       input logic [31:0] tg, input bit fl, input logic [31:0] fp);
    bit   pop, ce, fetch;
    ent_t e;
    @(negedge clk);
    rst                      = r_n;
    bus.rom_valid_i          = v;
    bus.id_ready_i           = rdy;
    bus.branch_flag_i        = br;
    bus.branch_target_addr_i = tg;
    bus.flush_i              = fl;
    bus.flush_pc_i           = fp;
    #1;
    last_ce    = bus.rom_ce_o;
    last_addr  = bus.rom_addr_o;
    last_valid = bus.id_valid_o;
    last_pc    = bus.id_pc_o;
    if (!r_n) begin
      mq.delete();
      mpc  = RESET_PC;
      mtgt = '0;
      slot = 1'b0;
    end
    pop   = r_n && (mq.size() > 0) && rdy;
    ce    = r_n && !fl && ((mq.size() < DEPTH) || pop);
    fetch = ce && v;
    chk("rom_ce", 32'(bus.rom_ce_o), 32'(ce));
    chk("rom_addr", bus.rom_addr_o, mpc);
    chk("id_valid", 32'(bus.id_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("head_pc", bus.id_pc_o, mq[0].pc);
      chk("head_inst", bus.id_inst_o, mq[0].inst);
    end else if (!r_n) begin
      chk("rst_id_pc", bus.id_pc_o, 32'h0);
      chk("rst_id_inst", bus.id_inst_o, 32'h0);
    end
    if (!r_n) return;
    if (pop) sb.push_back(mq[0]);
    e.pc   = mpc;
    e.inst = rom_of(mpc);
    if (fl) begin
      mq.delete();
      mpc  = fp;
      slot = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (slot) begin
        if (fetch) begin
          mq.push_back(e);
          mpc  = mtgt;
          slot = 1'b0;
        end
      end else if (pop && br) begin
        if (mq.size() >= 1) begin
          mq   = mq[0:0];
          mpc  = tg;
        end else if (fetch) begin
          mq.push_back(e);
          mpc = tg;
        end else begin
          mtgt = tg;
          slot = 1'b1;
        end
      end else if (fetch) begin
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  // Scoreboard monitor: every DUT pop must match the next expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.id_valid_o && bus.id_ready_i) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc 0x%08h expected no pop at %0t", bus.id_pc_o, $time);
        end else begin
          e = sb.pop_front();
          chk("pop_pc", bus.id_pc_o, e.pc);
          chk("pop_inst", bus.id_inst_o, e.inst);
        end
      end
    end
  end

  initial begin
    bus.rom_valid_i          = 1'b0;
    bus.id_ready_i           = 1'b0;
    bus.branch_flag_i        = 1'b0;
    bus.branch_target_addr_i = '0;
    bus.flush_i              = 1'b0;
    bus.flush_pc_i           = '0;

    // Reset, then steady streaming.
    repeat (2) cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("steady_addr0", last_addr, 32'h0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("steady_addr1", last_addr, 32'h4);
    chk("steady_head0", last_pc, 32'h0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("steady_addr2", last_addr, 32'h8);

    // Full queue, then simultaneous push and pop.
    cycle(1, 1, 1, 0, 0, 1, 32'h0);
    repeat (4) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("full_ce", 32'(last_ce), 32'h0);
    chk("full_addr", last_addr, 32'h10);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("full_pushpop_ce", 32'(last_ce), 32'h1);
    chk("full_pushpop_head", last_pc, 32'h0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("full_after_head", last_pc, 32'h4);
    chk("full_after_ce", 32'(last_ce), 32'h0);

    // Queued delay slot: {0x10 br, 0x14, 0x18}.
    cycle(1, 1, 1, 0, 0, 1, 32'h10);
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'h100, 0, 0);
    chk("ds_branch_head", last_pc, 32'h10);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("ds_slot_head", last_pc, 32'h14);
    chk("ds_target_req", last_addr, 32'h100);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("ds_target_head", last_pc, 32'h100);

    // SLOT_WAIT: branch popped from an otherwise empty queue, ROM stalls.
    cycle(1, 1, 1, 0, 0, 1, 32'h200);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 32'h300, 0, 0);
    chk("sw_branch_head", last_pc, 32'h200);
    cycle(1, 0, 1, 1, 32'h400, 0, 0);
    chk("sw_hold1", last_addr, 32'h204);
    cycle(1, 0, 1, 0, 0, 0, 0);
    chk("sw_hold2", last_addr, 32'h204);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("sw_slot_req", last_addr, 32'h204);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("sw_target_req", last_addr, 32'h300);
    chk("sw_slot_head", last_pc, 32'h204);

    // Flush wins over a branch pop.
    cycle(1, 1, 1, 0, 0, 1, 32'h40);
    repeat (2) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'h500, 1, 32'h180);
    chk("flush_ce", 32'(last_ce), 32'h0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("flush_empty", 32'(last_valid), 32'h0);
    chk("flush_req", last_addr, 32'h180);

    // PC wrap-around.
    cycle(1, 1, 1, 0, 0, 1, 32'hFFFF_FFF8);
    cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("wrap_top", last_addr, 32'hFFFF_FFFC);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("wrap_zero", last_addr, 32'h0);

    // Reset asserted mid-operation with a non-empty queue.
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    chk("midrst_valid", 32'(last_valid), 32'h0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("midrst_req", last_addr, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tg, fp;
      tg = {$urandom} & 32'hFFFF_FFFC;
      fp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ({$urandom} & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 149) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 3) == 0,
            tg,
            $urandom_range(0, 24) == 0,
            fp);
    end

    cycle(1, 0, 0, 0, 0, 0, 0);
    #3;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
